// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Combinational-only content; no latency, no backpressure of its own.
package pipeline_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } muldiv_state_t;

    typedef struct packed {
        logic ld;
        logic clear;
    } stage_ctrl_t;

    localparam int REG_ZERO    = 0;
    localparam int MD_CNT_BITS = 8;

    function automatic stage_ctrl_t stage_ctrl(input logic ld, input logic clear);
        stage_ctrl_t c;
        c.ld    = ld;
        c.clear = clear;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW data-hazard detector between the ID sources and the EX/MEM destinations.
// Purely combinational, zero latency; it only reports a hazard, the sequencer decides.
// With forwarding only an EX load can cause a stall; without it any EX/MEM writer does.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_BITS = 5,
    parameter int FORWARDING    = 1
) (
    input  logic [REG_ADDR_BITS-1:0] id_rs,
    input  logic [REG_ADDR_BITS-1:0] id_rt,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic [REG_ADDR_BITS-1:0] ex_rd,
    input  logic [REG_ADDR_BITS-1:0] mem_rd,
    input  logic                     ex_regwrite,
    input  logic                     mem_regwrite,
    input  logic                     ex_memread,
    output logic                     data_hz
);

    localparam logic [REG_ADDR_BITS-1:0] ZERO_REG = REG_ADDR_BITS'(REG_ZERO);

    logic raw_ex;
    logic raw_mem;

    assign raw_ex  = ex_regwrite && (ex_rd != ZERO_REG) &&
                     ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign raw_mem = mem_regwrite && (mem_rd != ZERO_REG) &&
                     ((id_uses_rs && (id_rs == mem_rd)) || (id_uses_rt && (id_rt == mem_rd)));

    always_comb begin
        data_hz = 1'b0;
        if (FORWARDING != 0) begin
            data_hz = raw_ex && ex_memread;
        end else begin
            data_hz = raw_ex || raw_mem;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, with mul/div occupancy FSM and perf counters.
// Control outputs are combinational (zero latency); FSM and counters update on clk_i.
// dmem_wait_i freezes every stage; the mul/div unit keeps counting down while frozen.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_BITS  = 5,
    parameter int FORWARDING     = 1,
    parameter int MULDIV_LATENCY = 32,
    parameter int CNT_BITS       = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [REG_ADDR_BITS-1:0] id_rs_i,
    input  logic [REG_ADDR_BITS-1:0] id_rt_i,
    input  logic                     id_uses_rs_i,
    input  logic                     id_uses_rt_i,
    input  logic                     id_muldiv_i,
    input  logic                     id_reads_hilo_i,
    input  logic [REG_ADDR_BITS-1:0] ex_rd_i,
    input  logic [REG_ADDR_BITS-1:0] mem_rd_i,
    input  logic                     ex_regwrite_i,
    input  logic                     mem_regwrite_i,
    input  logic                     ex_memread_i,
    input  logic                     ex_branch_taken_i,
    input  logic                     dmem_wait_i,
    output logic                     pc_ld_o,
    output logic                     if_id_ld_o,
    output logic                     if_id_clear_o,
    output logic                     id_ex_ld_o,
    output logic                     id_ex_clear_o,
    output logic                     ex_mem_ld_o,
    output logic                     ex_mem_clear_o,
    output logic                     mem_wb_ld_o,
    output logic                     mem_wb_clear_o,
    output logic                     muldiv_start_o,
    output logic                     muldiv_busy_o,
    output logic [CNT_BITS-1:0]      stall_cnt_o,
    output logic [CNT_BITS-1:0]      flush_cnt_o
);

    muldiv_state_t          state_q, state_d;
    logic [MD_CNT_BITS-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_BITS-1:0]    stall_cnt_q, flush_cnt_q;

    logic data_hz, md_hz;
    logic do_flush, do_stall;
    stage_ctrl_t if_id, id_ex, ex_mem, mem_wb;

    hazard_detect #(
        .REG_ADDR_BITS(REG_ADDR_BITS),
        .FORWARDING   (FORWARDING)
    ) u_hazard (
        .id_rs       (id_rs_i),
        .id_rt       (id_rt_i),
        .id_uses_rs  (id_uses_rs_i),
        .id_uses_rt  (id_uses_rt_i),
        .ex_rd       (ex_rd_i),
        .mem_rd      (mem_rd_i),
        .ex_regwrite (ex_regwrite_i),
        .mem_regwrite(mem_regwrite_i),
        .ex_memread  (ex_memread_i),
        .data_hz     (data_hz)
    );

    assign md_hz    = (state_q != IDLE) && (id_muldiv_i || id_reads_hilo_i);
    assign do_flush = !dmem_wait_i && ex_branch_taken_i;
    assign do_stall = !dmem_wait_i && !ex_branch_taken_i && (data_hz || md_hz);

    always_comb begin
        pc_ld_o        = 1'b1;
        if_id          = stage_ctrl(1'b1, 1'b0);
        id_ex          = stage_ctrl(1'b1, 1'b0);
        ex_mem         = stage_ctrl(1'b1, 1'b0);
        mem_wb         = stage_ctrl(1'b1, 1'b0);
        muldiv_start_o = 1'b0;
        if (rst_i) begin
            pc_ld_o = 1'b0;
            if_id   = stage_ctrl(1'b0, 1'b1);
            id_ex   = stage_ctrl(1'b0, 1'b1);
            ex_mem  = stage_ctrl(1'b0, 1'b1);
            mem_wb  = stage_ctrl(1'b0, 1'b1);
        end else if (dmem_wait_i) begin
            pc_ld_o = 1'b0;
            if_id   = stage_ctrl(1'b0, 1'b0);
            id_ex   = stage_ctrl(1'b0, 1'b0);
            ex_mem  = stage_ctrl(1'b0, 1'b0);
            mem_wb  = stage_ctrl(1'b0, 1'b0);
        end else if (do_flush) begin
            if_id = stage_ctrl(1'b0, 1'b1);
            id_ex = stage_ctrl(1'b0, 1'b1);
        end else if (do_stall) begin
            pc_ld_o = 1'b0;
            if_id   = stage_ctrl(1'b0, 1'b0);
            id_ex   = stage_ctrl(1'b0, 1'b1);
        end else begin
            // md_hz is clear here, so a mul/div in ID implies the FSM is IDLE.
            muldiv_start_o = id_muldiv_i;
        end
    end

    assign if_id_ld_o     = if_id.ld;
    assign if_id_clear_o  = if_id.clear;
    assign id_ex_ld_o     = id_ex.ld;
    assign id_ex_clear_o  = id_ex.clear;
    assign ex_mem_ld_o    = ex_mem.ld;
    assign ex_mem_clear_o = ex_mem.clear;
    assign mem_wb_ld_o    = mem_wb.ld;
    assign mem_wb_clear_o = mem_wb.clear;

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        if (state_q == IDLE) begin
            if (muldiv_start_o) begin
                state_d  = BUSY;
                md_cnt_d = MD_CNT_BITS'(MULDIV_LATENCY - 1);
            end
        end else begin
            if (md_cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                md_cnt_d = md_cnt_q - MD_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (do_stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_BITS'(1);
            end
            if (do_flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_BITS'(1);
            end
        end
    end

    assign muldiv_busy_o = (state_q == BUSY);
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Drives one forwarding and one non-forwarding pipeline_ctrl with identical directed
// vectors; a cycle-level reference model plus hand-computed spot checks judge both.
module tb_pipeline_ctrl;

    localparam int LAT = 4;
    localparam int CB  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_uses_rs, id_uses_rt, id_muldiv, id_reads_hilo;
    logic       ex_regwrite, mem_regwrite, ex_memread, branch, dmem_wait;

    // index 1: FORWARDING=1 instance, index 0: FORWARDING=0 instance
    logic          pc_ld[2], if_id_ld[2], if_id_clear[2], id_ex_ld[2], id_ex_clear[2];
    logic          ex_mem_ld[2], ex_mem_clear[2], mem_wb_ld[2], mem_wb_clear[2];
    logic          md_start[2], md_busy[2];
    logic [CB-1:0] stall_cnt[2], flush_cnt[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_ADDR_BITS(5), .FORWARDING(1), .MULDIV_LATENCY(LAT), .CNT_BITS(CB)) u_fwd1 (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
        .id_muldiv_i(id_muldiv), .id_reads_hilo_i(id_reads_hilo),
        .ex_rd_i(ex_rd), .mem_rd_i(mem_rd), .ex_regwrite_i(ex_regwrite), .mem_regwrite_i(mem_regwrite),
        .ex_memread_i(ex_memread), .ex_branch_taken_i(branch), .dmem_wait_i(dmem_wait),
        .pc_ld_o(pc_ld[1]), .if_id_ld_o(if_id_ld[1]), .if_id_clear_o(if_id_clear[1]),
        .id_ex_ld_o(id_ex_ld[1]), .id_ex_clear_o(id_ex_clear[1]),
        .ex_mem_ld_o(ex_mem_ld[1]), .ex_mem_clear_o(ex_mem_clear[1]),
        .mem_wb_ld_o(mem_wb_ld[1]), .mem_wb_clear_o(mem_wb_clear[1]),
        .muldiv_start_o(md_start[1]), .muldiv_busy_o(md_busy[1]),
        .stall_cnt_o(stall_cnt[1]), .flush_cnt_o(flush_cnt[1])
    );

    pipeline_ctrl #(.REG_ADDR_BITS(5), .FORWARDING(0), .MULDIV_LATENCY(LAT), .CNT_BITS(CB)) u_fwd0 (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
        .id_muldiv_i(id_muldiv), .id_reads_hilo_i(id_reads_hilo),
        .ex_rd_i(ex_rd), .mem_rd_i(mem_rd), .ex_regwrite_i(ex_regwrite), .mem_regwrite_i(mem_regwrite),
        .ex_memread_i(ex_memread), .ex_branch_taken_i(branch), .dmem_wait_i(dmem_wait),
        .pc_ld_o(pc_ld[0]), .if_id_ld_o(if_id_ld[0]), .if_id_clear_o(if_id_clear[0]),
        .id_ex_ld_o(id_ex_ld[0]), .id_ex_clear_o(id_ex_clear[0]),
        .ex_mem_ld_o(ex_mem_ld[0]), .ex_mem_clear_o(ex_mem_clear[0]),
        .mem_wb_ld_o(mem_wb_ld[0]), .mem_wb_clear_o(mem_wb_clear[0]),
        .muldiv_start_o(md_start[0]), .muldiv_busy_o(md_busy[0]),
        .stall_cnt_o(stall_cnt[0]), .flush_cnt_o(flush_cnt[0])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s fwd=%0d at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Reference model: mul/div occupancy kept as "last busy cycle number".
    int  cyc = 0;
    bit  valid = 0;
    int  busy_end[2] = '{-1, -1};
    int  m_stall[2]  = '{0, 0};
    int  m_flush[2]  = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic rex, rmem, dhz, mhz, bsy, frz, fl, st, e_pc, e_start;
            logic [3:0] e_ld, e_clr, a_ld, a_clr, mask;
            rex  = ex_regwrite && (ex_rd != 5'd0) &&
                   ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
            rmem = mem_regwrite && (mem_rd != 5'd0) &&
                   ((id_uses_rs && id_rs == mem_rd) || (id_uses_rt && id_rt == mem_rd));
            dhz  = (k == 1) ? (rex && ex_memread) : (rex || rmem);
            bsy  = (cyc <= busy_end[k]);
            mhz  = bsy && (id_muldiv || id_reads_hilo);
            frz  = dmem_wait;
            fl   = !frz && branch;
            st   = !frz && !fl && (dhz || mhz);
            e_start = 1'b0;
            // bit order: {mem_wb, ex_mem, id_ex, if_id}
            if (rst) begin
                e_pc = 1'b0; e_ld = 4'h0; e_clr = 4'hf;
            end else if (frz) begin
                e_pc = 1'b0; e_ld = 4'h0; e_clr = 4'h0;
            end else if (fl) begin
                e_pc = 1'b1; e_ld = 4'b1100; e_clr = 4'b0011;
            end else if (st) begin
                e_pc = 1'b0; e_ld = 4'b1100; e_clr = 4'b0010;
            end else begin
                e_pc = 1'b1; e_ld = 4'hf; e_clr = 4'h0; e_start = id_muldiv;
            end
            if (valid) begin
                a_clr = {mem_wb_clear[k], ex_mem_clear[k], id_ex_clear[k], if_id_clear[k]};
                a_ld  = {mem_wb_ld[k], ex_mem_ld[k], id_ex_ld[k], if_id_ld[k]};
                mask  = rst ? 4'hf : ~e_clr;
                chk("model_pc_ld", k, 32'(pc_ld[k]), 32'(e_pc));
                chk("model_clear", k, 32'(a_clr), 32'(e_clr));
                chk("model_ld", k, 32'(a_ld & mask), 32'(e_ld & mask));
                chk("model_start", k, 32'(md_start[k]), 32'(e_start));
                chk("model_busy", k, 32'(md_busy[k]), 32'(bsy));
                chk("model_stall_cnt", k, 32'(stall_cnt[k]), 32'(m_stall[k]));
                chk("model_flush_cnt", k, 32'(flush_cnt[k]), 32'(m_flush[k]));
            end
            if (rst) begin
                busy_end[k] = -1;
                m_stall[k]  = 0;
                m_flush[k]  = 0;
            end else begin
                if (e_start) busy_end[k] = cyc + LAT;
                if (st) m_stall[k] = (m_stall[k] + 1) % (1 << CB);
                if (fl) m_flush[k] = (m_flush[k] + 1) % (1 << CB);
            end
        end
        if (rst) valid = 1;
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_muldiv = 1'b0; id_reads_hilo = 1'b0;
        ex_regwrite = 1'b0; mem_regwrite = 1'b0; ex_memread = 1'b0;
        branch = 1'b0; dmem_wait = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        nxt(); nxt();
        #2;
        chk("rst_if_id_clear", 1, 32'(if_id_clear[1]), 32'd1);
        chk("rst_mem_wb_clear", 1, 32'(mem_wb_clear[1]), 32'd1);
        chk("rst_pc_ld", 1, 32'(pc_ld[1]), 32'd0);
        chk("rst_ex_mem_ld", 1, 32'(ex_mem_ld[1]), 32'd0);
        chk("rst_busy", 1, 32'(md_busy[1]), 32'd0);
        chk("rst_stall_cnt", 1, 32'(stall_cnt[1]), 32'd0);
        nxt();
        rst = 1'b0;
        idle_in();                                        // C0
        nxt();
        ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8;   // C1 load-use
        id_rs = 5'd8; id_uses_rs = 1'b1;
        #2;
        chk("lu_pc_ld", 1, 32'(pc_ld[1]), 32'd0);
        chk("lu_id_ex_clear", 1, 32'(id_ex_clear[1]), 32'd1);
        chk("lu_if_id_ld", 1, 32'(if_id_ld[1]), 32'd0);
        chk("lu_pc_ld", 0, 32'(pc_ld[0]), 32'd0);
        nxt();
        ex_regwrite = 1'b0; ex_memread = 1'b0;            // C2 load moved to MEM
        mem_rd = 5'd8; mem_regwrite = 1'b1;
        #2;
        chk("lu2_pc_ld", 1, 32'(pc_ld[1]), 32'd1);
        chk("lu2_stall_cnt", 1, 32'(stall_cnt[1]), 32'd1);
        chk("lu2_pc_ld", 0, 32'(pc_ld[0]), 32'd0);
        chk("lu2_stall_cnt", 0, 32'(stall_cnt[0]), 32'd1);
        nxt();
        idle_in();                                        // C3 ADD rd9 in EX
        ex_rd = 5'd9; ex_regwrite = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1;
        #2;
        chk("raw_ex_pc_ld", 0, 32'(pc_ld[0]), 32'd0);
        chk("raw_ex_pc_ld", 1, 32'(pc_ld[1]), 32'd1);
        chk("raw_ex_stall_cnt", 0, 32'(stall_cnt[0]), 32'd2);
        nxt();
        ex_regwrite = 1'b0; mem_rd = 5'd9; mem_regwrite = 1'b1;   // C4 producer in MEM
        #2;
        chk("raw_mem_pc_ld", 0, 32'(pc_ld[0]), 32'd0);
        chk("raw_mem_stall_cnt", 0, 32'(stall_cnt[0]), 32'd3);
        nxt();
        idle_in();                                        // C5 rd=0 never hazards
        ex_rd = 5'd0; ex_regwrite = 1'b1; mem_regwrite = 1'b1;
        id_rt = 5'd0; id_uses_rt = 1'b1;
        #2;
        chk("r0_pc_ld", 0, 32'(pc_ld[0]), 32'd1);
        chk("r0_id_ex_clear", 0, 32'(id_ex_clear[0]), 32'd0);
        chk("r0_stall_cnt", 0, 32'(stall_cnt[0]), 32'd4);
        nxt();
        idle_in();                                        // C6 branch over load-use
        ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8;
        id_rs = 5'd8; id_uses_rs = 1'b1; branch = 1'b1;
        #2;
        chk("br_if_id_clear", 1, 32'(if_id_clear[1]), 32'd1);
        chk("br_id_ex_clear", 1, 32'(id_ex_clear[1]), 32'd1);
        chk("br_pc_ld", 1, 32'(pc_ld[1]), 32'd1);
        nxt();
        idle_in(); id_muldiv = 1'b1;                      // C7 MULT issues
        #2;
        chk("br_flush_cnt", 1, 32'(flush_cnt[1]), 32'd1);
        chk("br_stall_cnt", 1, 32'(stall_cnt[1]), 32'd1);
        chk("br_stall_cnt", 0, 32'(stall_cnt[0]), 32'd4);
        chk("md_start", 1, 32'(md_start[1]), 32'd1);
        nxt();
        idle_in(); id_reads_hilo = 1'b1;                  // C8..C11 MFLO stalls
        for (int i = 0; i < LAT; i++) begin
            #2;
            chk("md_wait_start", 1, 32'(md_start[1]), 32'd0);
            chk("md_wait_busy", 1, 32'(md_busy[1]), 32'd1);
            chk("md_wait_pc_ld", 1, 32'(pc_ld[1]), 32'd0);
            nxt();
        end
        #2;                                               // C12 MFLO proceeds
        chk("md_done_busy", 1, 32'(md_busy[1]), 32'd0);
        chk("md_done_pc_ld", 1, 32'(pc_ld[1]), 32'd1);
        chk("md_done_stall_cnt", 1, 32'(stall_cnt[1]), 32'd5);
        chk("md_done_stall_cnt", 0, 32'(stall_cnt[0]), 32'd8);
        nxt();
        idle_in(); id_muldiv = 1'b1;                      // C13 second MULT
        #2;
        chk("md2_start", 1, 32'(md_start[1]), 32'd1);
        nxt();
        idle_in(); id_reads_hilo = 1'b1; dmem_wait = 1'b1;    // C14..C16 frozen
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("frz_pc_ld", 1, 32'(pc_ld[1]), 32'd0);
            chk("frz_if_id_ld", 1, 32'(if_id_ld[1]), 32'd0);
            chk("frz_id_ex_clear", 1, 32'(id_ex_clear[1]), 32'd0);
            chk("frz_mem_wb_ld", 1, 32'(mem_wb_ld[1]), 32'd0);
            chk("frz_stall_cnt", 1, 32'(stall_cnt[1]), 32'd5);
            nxt();
        end
        dmem_wait = 1'b0;                                 // C17 last busy cycle
        #2;
        chk("frz_end_busy", 1, 32'(md_busy[1]), 32'd1);
        chk("frz_end_pc_ld", 1, 32'(pc_ld[1]), 32'd0);
        nxt();
        #2;                                               // C18
        chk("frz_idle_busy", 1, 32'(md_busy[1]), 32'd0);
        chk("frz_idle_pc_ld", 1, 32'(pc_ld[1]), 32'd1);
        chk("frz_stall_cnt2", 0, 32'(stall_cnt[0]), 32'd9);
        nxt();
        idle_in(); id_muldiv = 1'b1; branch = 1'b1;       // C19 flushed MULT
        #2;
        chk("br_md_start", 1, 32'(md_start[1]), 32'd0);
        chk("br_md_if_id_clear", 1, 32'(if_id_clear[1]), 32'd1);
        nxt();
        idle_in();                                        // C20
        #2;
        chk("br_md_busy", 1, 32'(md_busy[1]), 32'd0);
        chk("br_md_flush_cnt", 1, 32'(flush_cnt[1]), 32'd2);
        nxt();
        branch = 1'b1; dmem_wait = 1'b1;                  // C21 freeze beats branch
        #2;
        chk("brfrz_if_id_clear", 1, 32'(if_id_clear[1]), 32'd0);
        chk("brfrz_pc_ld", 1, 32'(pc_ld[1]), 32'd0);
        nxt();
        dmem_wait = 1'b0;                                 // C22 branch re-evaluated
        #2;
        chk("brfrz2_if_id_clear", 1, 32'(if_id_clear[1]), 32'd1);
        chk("brfrz2_flush_cnt", 1, 32'(flush_cnt[1]), 32'd2);
        nxt();
        idle_in(); id_muldiv = 1'b1;                      // C23
        #2;
        chk("rstmd_flush_cnt", 1, 32'(flush_cnt[1]), 32'd3);
        chk("rstmd_start", 1, 32'(md_start[1]), 32'd1);
        nxt();
        idle_in();                                        // C24
        #2;
        chk("rstmd_busy", 1, 32'(md_busy[1]), 32'd1);
        nxt();
        rst = 1'b1;                                       // C25 reset mid-BUSY
        #2;
        chk("rstmd_busy_held", 1, 32'(md_busy[1]), 32'd1);
        chk("rstmd_id_ex_clear", 1, 32'(id_ex_clear[1]), 32'd1);
        chk("rstmd_pc_ld", 1, 32'(pc_ld[1]), 32'd0);
        nxt();
        #2;                                               // C26
        chk("rstmd2_busy", 1, 32'(md_busy[1]), 32'd0);
        chk("rstmd2_stall_cnt", 1, 32'(stall_cnt[1]), 32'd0);
        chk("rstmd2_flush_cnt", 1, 32'(flush_cnt[1]), 32'd0);
        chk("rstmd2_ex_mem_clear", 1, 32'(ex_mem_clear[1]), 32'd1);
        nxt();
        rst = 1'b0;                                       // C27
        #2;
        chk("post_rst_pc_ld", 1, 32'(pc_ld[1]), 32'd1);
        chk("post_rst_busy", 0, 32'(md_busy[0]), 32'd0);
        nxt();
        nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It evaluates data hazards, taken branches, data-memory wait and the multi-cycle multiply/divide unit. It drives the `ld_i`/`clear_i` pins of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC load enable. It owns the mul/div occupancy FSM and two performance counters.

## Interface

**Parameters**
- `REG_ADDR_BITS`, default 5: register-file address width.
- `FORWARDING`, default 1: 1 means a forwarding network exists, so only load-use stalls. 0 means stall on any RAW against EX or MEM.
- `MULDIV_LATENCY`, default 32: cycles the mul/div unit is busy after issue. Legal range is 2..255.
- `CNT_BITS`, default 32: width of the performance counters.

**Ports**
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `id_rs_i`, `id_rt_i` in REG_ADDR_BITS: source registers of the instruction in ID.
- `id_uses_rs_i`, `id_uses_rt_i` in 1: the ID instruction actually reads rs / rt.
- `id_muldiv_i` in 1: the ID instruction is MULT/MULTU/DIV/DIVU.
- `id_reads_hilo_i` in 1: the ID instruction is MFHI/MFLO.
- `ex_rd_i`, `mem_rd_i` in REG_ADDR_BITS: destination register in EX / MEM.
- `ex_regwrite_i`, `mem_regwrite_i` in 1: the instruction in EX / MEM writes the register file.
- `ex_memread_i` in 1: the EX instruction is a load.
- `ex_branch_taken_i` in 1: a branch or jump resolved taken in EX.
- `dmem_wait_i` in 1: data memory not ready; the whole pipeline must freeze.
- `pc_ld_o` out 1: PC load enable.
- `if_id_ld_o`, `if_id_clear_o` out 1: IF/ID register load and clear.
- `id_ex_ld_o`, `id_ex_clear_o` out 1: ID/EX register load and clear.
- `ex_mem_ld_o`, `ex_mem_clear_o` out 1: EX/MEM register load and clear.
- `mem_wb_ld_o`, `mem_wb_clear_o` out 1: MEM/WB register load and clear.
- `muldiv_start_o` out 1: one-cycle issue pulse to the mul/div unit.
- `muldiv_busy_o` out 1: the mul/div FSM is not IDLE.
- `stall_cnt_o` out CNT_BITS: count of cycles in which the front end stalled.
- `flush_cnt_o` out CNT_BITS: count of taken-branch flush events.

## Operation

**Hazard terms (combinational)**
- `raw_ex`: the ID instruction reads a register that EX writes. True when `ex_regwrite_i` is set, `ex_rd_i` ≠ 0, and `ex_rd_i` equals `id_rs_i` (with `id_uses_rs_i`) or `id_rt_i` (with `id_uses_rt_i`).
- `raw_mem`: the same test against `mem_rd_i` / `mem_regwrite_i`.
- `data_hz`:
  - FORWARDING=1: `raw_ex` & `ex_memread_i`.
  - FORWARDING=0: `raw_ex` | `raw_mem`.
- `md_hz`: FSM is not IDLE and (`id_muldiv_i` | `id_reads_hilo_i`).

**Priority of pipeline actions (one action per cycle)**
1. **Freeze** (`dmem_wait_i`=1): all `ld` = 0, all `clear` = 0, `pc_ld_o` = 0.
2. **Flush** (`ex_branch_taken_i`=1):
   - `if_id_clear_o` = 1 and `id_ex_clear_o` = 1.
   - `pc_ld_o` = 1, `ex_mem_ld_o` = 1, `mem_wb_ld_o` = 1.
   - A pending stall is discarded.
3. **Stall** (`data_hz` | `md_hz`):
   - `pc_ld_o` = 0 and `if_id_ld_o` = 0.
   - `id_ex_clear_o` = 1, which inserts a bubble.
   - EX/MEM and MEM/WB load normally.
4. **Normal**: every `ld` = 1, every `clear` = 0.

`clear` takes priority over `ld` inside the register, so the `ld` value is don't-care whenever `clear` = 1.

**Mul/div FSM**
- States: IDLE, BUSY.
- Transition IDLE→BUSY: when `id_muldiv_i`=1 and the cycle is Normal (not frozen, flushed or stalled).
  - `muldiv_start_o` = 1 in that same cycle.
  - The down-counter loads `MULDIV_LATENCY-1`.
- BUSY: the counter decrements every cycle, including frozen cycles, because the unit runs independently.
- Transition BUSY→IDLE: on the cycle the counter equals 0.
- During BUSY, a second mul/div or an MFHI/MFLO stalls in ID. The first such instruction issues on the first cycle after the FSM returns to IDLE.
- `muldiv_busy_o` is 1 exactly when the state is BUSY.

**Performance counters**
- `stall_cnt_o` increments on every Stall-action cycle.
- `flush_cnt_o` increments on every Flush-action cycle.
- Frozen cycles are not counted.
- Both counters wrap modulo 2^CNT_BITS.

## Timing
- All pipeline control outputs and `muldiv_start_o` are combinational from inputs and current state, with zero latency. They must settle before the same clock edge they control.
- Reset (synchronous, applies at the edge where `rst_i`=1):
  - State ← IDLE, counter ← 0, `stall_cnt_o` ← 0, `flush_cnt_o` ← 0.
  - While `rst_i`=1: all `clear` outputs = 1, all `ld` outputs = 0, `pc_ld_o` = 0, `muldiv_start_o` = 0.
  - Reset during BUSY aborts the FSM to IDLE.
- Load-use with FORWARDING=1: exactly 1 stall cycle.
- RAW with FORWARDING=0: 2 stall cycles if the producer is in EX, 1 stall cycle if it is in MEM.
- An MFHI issued right after a MULT sees `MULDIV_LATENCY` stall cycles, counted from the cycle after `muldiv_start_o`.
- Branch taken and freeze in the same cycle: freeze wins; the branch is re-evaluated next cycle, because EX is held.
- Branch taken while a mul/div sits in ID: the mul/div is flushed and does not issue (`muldiv_start_o` = 0).

## Structure
- Shared package `pipeline_pkg`:
  - Enum `muldiv_state_t` with values IDLE and BUSY.
  - A packed struct `stage_ctrl_t` holding `{ld, clear}`.
  - Constant `REG_ZERO` = 0.
- One sub-module, `hazard_detect`: purely combinational, produces `data_hz` from the register fields and the FORWARDING parameter.
- The FSM, the action priority logic and the counters live in `pipeline_ctrl`.

## Test plan
- **Load-use, FORWARDING=1:** EX holds LW with `ex_rd_i`=8; ID reads rs=8 → exactly 1 cycle with `pc_ld_o`=0 and `id_ex_clear_o`=1; `stall_cnt_o` increases by 1.
- **RAW without forwarding, FORWARDING=0:** ADD with rd=9 is in EX, ID reads rt=9 → 2 stall cycles; the same case with rd=0 → no stall.
- **Branch over stall:** `ex_branch_taken_i`=1 together with a load-use hazard → `if_id_clear_o`=1, `id_ex_clear_o`=1, `pc_ld_o`=1; `flush_cnt_o` increases by 1 and `stall_cnt_o` is unchanged.
- **Mul/div:** MULT issues, then MFLO is in ID with MULDIV_LATENCY=4 → `muldiv_start_o` pulses once; 4 stall cycles follow; MFLO proceeds on cycle 5.
- **Freeze:** `dmem_wait_i` held for 3 cycles during BUSY → all `ld`/`clear` outputs = 0 and the counters do not move; the FSM counter still decrements and BUSY ends on schedule.
- **Reset:** `rst_i` asserted mid-BUSY → the next cycle shows state IDLE, `muldiv_busy_o`=0, both counters 0, and all `clear` outputs = 1 while reset is held.
